// File: rtl/echo_feedback_mixer_if.sv
// Sample/gain bundle between the echo delay buffer, its source and the feedback mixer.
// master drives samples and gain targets; slave is the mixer side.
interface echo_feedback_mixer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_WIDTH = 16
);
  logic                         sample_valid;
  logic signed [DATA_WIDTH-1:0] dry_sample;
  logic signed [DATA_WIDTH-1:0] delayed_sample;
  logic                         delayed_valid;
  logic        [GAIN_WIDTH-1:0] feedback_target;
  logic        [GAIN_WIDTH-1:0] mix_target;
  logic signed [DATA_WIDTH-1:0] buf_sample;
  logic                         buf_sample_valid;
  logic signed [DATA_WIDTH-1:0] out_sample;
  logic                         out_sample_valid;
  logic        [GAIN_WIDTH-1:0] feedback_gain;
  logic        [GAIN_WIDTH-1:0] mix_gain;

  modport master (
    output sample_valid, dry_sample, delayed_sample, delayed_valid,
           feedback_target, mix_target,
    input  buf_sample, buf_sample_valid, out_sample, out_sample_valid,
           feedback_gain, mix_gain
  );

  modport slave (
    input  sample_valid, dry_sample, delayed_sample, delayed_valid,
           feedback_target, mix_target,
    output buf_sample, buf_sample_valid, out_sample, out_sample_valid,
           feedback_gain, mix_gain
  );
endinterface

// File: rtl/echo_feedback_mixer.sv
// Echo loop mixer: slew-limited wet/feedback gains, 3-stage saturating mix of the dry
// and delayed samples into the effect output and the delay-buffer write-back sample.
module echo_feedback_mixer #(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_WIDTH = 16,
  parameter int SLEW_STEP  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  echo_feedback_mixer_if.slave  bus
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;

  localparam logic signed [GAIN_WIDTH+1:0] STEP = (GAIN_WIDTH+2)'(SLEW_STEP);
  localparam logic signed [GAIN_WIDTH+1:0] GMAX = {2'b00, {GAIN_WIDTH{1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic [GAIN_WIDTH-1:0] slew(input logic [GAIN_WIDTH-1:0] cur,
                                                 input logic [GAIN_WIDTH-1:0] tgt);
    logic signed [GAIN_WIDTH+1:0] c, t, diff, nxt;
    c    = $signed({2'b00, cur});
    t    = $signed({2'b00, tgt});
    diff = t - c;
    if (diff > STEP)       nxt = c + STEP;
    else if (diff < -STEP) nxt = c - STEP;
    else                   nxt = t;
    if (nxt < 0)           nxt = '0;
    else if (nxt > GMAX)   nxt = GMAX;
    return nxt[GAIN_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] v);
    if (v[DATA_WIDTH] != v[DATA_WIDTH-1]) return v[DATA_WIDTH] ? SMIN : SMAX;
    return v[DATA_WIDTH-1:0];
  endfunction

  logic [GAIN_WIDTH-1:0] fb_gain, mx_gain;
  logic [GAIN_WIDTH-1:0] fb_gain_next, mx_gain_next;

  logic                         s1_valid;
  logic signed [DATA_WIDTH-1:0] s1_dry, s1_d;
  logic        [GAIN_WIDTH-1:0] s1_fb_gain, s1_mx_gain;

  logic                         s2_valid;
  logic signed [DATA_WIDTH-1:0] s2_dry;
  logic signed [PW-1:0]         s2_fb_prod, s2_mx_prod;

  logic signed [DATA_WIDTH:0]   fb_sum, mx_sum;

  always_comb begin
    fb_gain_next = slew(fb_gain, bus.feedback_target);
    mx_gain_next = slew(mx_gain, bus.mix_target);
    // Upper DATA_WIDTH+1 product bits are exactly the floor-shifted term (>>> GAIN_WIDTH).
    fb_sum = $signed({s2_dry[DATA_WIDTH-1], s2_dry}) + $signed(s2_fb_prod[PW-1:GAIN_WIDTH]);
    mx_sum = $signed({s2_dry[DATA_WIDTH-1], s2_dry}) + $signed(s2_mx_prod[PW-1:GAIN_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_gain              <= '0;
      mx_gain              <= '0;
      s1_valid             <= 1'b0;
      s1_dry               <= '0;
      s1_d                 <= '0;
      s1_fb_gain           <= '0;
      s1_mx_gain           <= '0;
      s2_valid             <= 1'b0;
      s2_dry               <= '0;
      s2_fb_prod           <= '0;
      s2_mx_prod           <= '0;
      bus.buf_sample       <= '0;
      bus.out_sample       <= '0;
      bus.buf_sample_valid <= 1'b0;
      bus.out_sample_valid <= 1'b0;
    end else begin
      s1_valid <= bus.sample_valid;
      if (bus.sample_valid) begin
        s1_dry     <= bus.dry_sample;
        s1_d       <= bus.delayed_valid ? bus.delayed_sample : '0;
        s1_fb_gain <= fb_gain;
        s1_mx_gain <= mx_gain;
        fb_gain    <= fb_gain_next;
        mx_gain    <= mx_gain_next;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_dry     <= s1_dry;
        s2_fb_prod <= $signed({{(GAIN_WIDTH+1){s1_d[DATA_WIDTH-1]}}, s1_d})
                    * $signed({{(DATA_WIDTH+1){1'b0}}, s1_fb_gain});
        s2_mx_prod <= $signed({{(GAIN_WIDTH+1){s1_d[DATA_WIDTH-1]}}, s1_d})
                    * $signed({{(DATA_WIDTH+1){1'b0}}, s1_mx_gain});
      end

      bus.buf_sample_valid <= s2_valid;
      bus.out_sample_valid <= s2_valid;
      if (s2_valid) begin
        bus.buf_sample <= sat(fb_sum);
        bus.out_sample <= sat(mx_sum);
      end
    end
  end

  assign bus.feedback_gain = fb_gain;
  assign bus.mix_gain      = mx_gain;

endmodule
